pipo1: RTL and testbench
========================

PIPO1 -- requirements
Module: pipo1

Interface
- REQ-001: Parameter WIDTH SHALL be 32 by default and set the data path width in bits.
- REQ-002: Port clk SHALL be an input, 1 bit, the sole clock; all state updates occur on its rising edge.
- REQ-003: Port rst SHALL be an input, 1 bit, the reset; reset is synchronous and active-high.
- REQ-004: Port I SHALL be an input, WIDTH bits, the parallel data input.
- REQ-005: Port sel SHALL be an input, 1 bit, the load enable: 1 = load I, 0 = hold.
- REQ-006: Port QB SHALL be an output, WIDTH bits, the parallel register output, non-inverted and driven directly from the register.
- REQ-007: Port declaration order SHALL be I, sel, clk, QB, rst, so that existing positional instantiations of the first four ports remain valid.

Function
- REQ-008: The block SHALL be a single WIDTH-bit parallel-in parallel-out register clocked on the rising edge of clk.
- REQ-009: On a rising edge with rst=0 and sel=1, the register SHALL capture I, and QB SHALL equal that I value after the edge (one-edge latency).
- REQ-010: On a rising edge with rst=0 and sel=0, the register SHALL hold its value, and QB SHALL stay unchanged regardless of I.
- REQ-011: QB SHALL not change between rising edges.
- REQ-012: QB SHALL have no combinational path from I or sel.
- REQ-013: All WIDTH bits SHALL load or hold together; there is no partial-word update, no shifting and no bit inversion.
- REQ-014: A change to I while sel=0 SHALL have no effect on QB, including at the edge where sel returns to 1, where the I value present at that edge is the one loaded.
- REQ-015: Before the first reset or load edge, QB is unknown (X in simulation); no power-up value is guaranteed.

Reset
- REQ-016: On a rising edge with rst=1, the register SHALL clear to 0, and QB SHALL be 0 after that edge.
- REQ-017: rst SHALL take priority over sel; with rst=1 and sel=1, QB becomes 0 and I is ignored.
- REQ-018: Assertion of rst between clock edges SHALL have no effect until the next rising edge (synchronous reset).
- REQ-019: After rst deasserts, normal load and hold behaviour SHALL resume at the next rising edge.

Verification
- REQ-020: Reset: hold rst=1 for one edge with sel=1 and I=15 -> QB=0; then drop rst with sel=1 and I=15 -> QB=15 after the next edge.
- REQ-021: Consecutive loads: with sel=1 apply I=15, then 1, then 6 on successive edges -> QB reads 15, 1, 6 after each respective edge.
- REQ-022: Hold: with QB=6, set sel=0 and I=5 for one edge -> QB stays 6.
- REQ-023: Hold then load: from the hold state, sel=1 with I=10 then I=2 -> QB=10 then QB=2; then sel=0 with I=23 -> QB stays 2.
- REQ-024: Full-width patterns: load 32'hFFFFFFFF, then 32'h80000001 -> QB matches exactly; a mid-cycle change of I with no edge -> QB unchanged.
- REQ-025: Priority: rst=1, sel=1, I=32'hA5A5A5A5 at an edge while QB is nonzero -> QB=0 after that edge.

Source files
------------

// File: rtl/pipo1.sv
// WIDTH-bit parallel-in parallel-out register with load enable and
// synchronous active-high clear. QB comes straight from the flops.
module pipo1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] I,
    input  logic             sel,
    input  logic             clk,
    output logic [WIDTH-1:0] QB,
    input  logic             rst
);

    // Clear beats load; with sel low the whole word holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            QB <= '0;
        end else if (sel) begin
            QB <= I;
        end
    end

endmodule

// File: tb/tb_pipo1.sv
// Randomized and directed bench for pipo1 against a behavioural register model.
module tb_pipo1;

    localparam int WIDTH = 32;

    logic [WIDTH-1:0] I;
    logic             sel;
    logic             clk;
    logic [WIDTH-1:0] QB;
    logic             rst;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] model_q;
    bit               model_known;

    pipo1 #(.WIDTH(WIDTH)) dut (
        .I   (I),
        .sel (sel),
        .clk (clk),
        .QB  (QB),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: QB=%h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs (called at edge+1), clock it, update the model.
    task automatic step(input logic r, input logic s, input logic [WIDTH-1:0] d);
        rst = r;
        sel = s;
        I   = d;
        @(posedge clk);
        #1;
        if (r) begin
            model_q     = '0;
            model_known = 1'b1;
        end else if (s) begin
            model_q     = d;
            model_known = 1'b1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_q     = '0;
        model_known = 1'b0;
        rst = 1'b0;
        sel = 1'b0;
        I   = '0;
        @(posedge clk);
        #1;

        // Reset with load asserted, then release and load 15
        step(1'b1, 1'b1, 32'd15);
        check("reset_clear", QB, 32'd0);
        step(1'b0, 1'b1, 32'd15);
        check("post_reset_load", QB, 32'd15);

        // Consecutive loads
        step(1'b0, 1'b1, 32'd1);
        check("load_1", QB, 32'd1);
        step(1'b0, 1'b1, 32'd6);
        check("load_6", QB, 32'd6);

        // Hold
        step(1'b0, 1'b0, 32'd5);
        check("hold_6", QB, 32'd6);

        // Hold then load, then hold again
        step(1'b0, 1'b1, 32'd10);
        check("load_10", QB, 32'd10);
        step(1'b0, 1'b1, 32'd2);
        check("load_2", QB, 32'd2);
        step(1'b0, 1'b0, 32'd23);
        check("hold_2", QB, 32'd2);

        // Full-width patterns
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        check("load_all_ones", QB, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'h8000_0001);
        check("load_edges", QB, 32'h8000_0001);

        // Mid-cycle change of I with load enabled: no edge, no change
        I = 32'h1234_5678;
        #3;
        check("midcycle_i", QB, 32'h8000_0001);
        #1;

        // Mid-cycle reset assertion has no effect until the edge
        @(posedge clk);
        #1;
        model_q = 32'h1234_5678;
        check("edge_after_midcycle", QB, model_q);
        rst = 1'b1;
        sel = 1'b0;
        #3;
        check("midcycle_rst", QB, 32'h1234_5678);
        #1;

        // Reset priority over load with nonzero contents
        step(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("nonzero_before_rst", QB, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 32'hA5A5_A5A5);
        check("rst_priority", QB, 32'd0);
        step(1'b0, 1'b0, 32'hA5A5_A5A5);
        check("hold_after_rst", QB, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 $urandom());
            if (model_known) check("random", QB, model_q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
